// File: rtl/sti_rx_deserializer_if.sv
// Bundled serial-in / parallel-out signals of the STI receive deserializer.
// Optional pad checking in the attached block is controlled by PAD_CHECK_EN.
interface sti_rx_deserializer_if #(
  parameter int CNT_W = 8
);
  // Serial side has no back-pressure: every cycle with si_valid=1 carries one bit
  // that must be consumed. po_valid/abort_err/pad_err are single-cycle strobes
  // with no ready; po_data and frame_cnt are level outputs held between frames.
  logic             si_data;
  logic             si_valid;
  logic [1:0]       cfg_length;
  logic             cfg_msb;
  logic             cfg_fill;
  logic             cfg_low;
  logic [15:0]      po_data;
  logic             po_valid;
  logic             abort_err;
  logic             pad_err;
  logic [CNT_W-1:0] frame_cnt;
  logic             state_dbg;

  modport master (
    output si_data, si_valid, cfg_length, cfg_msb, cfg_fill, cfg_low,
    input  po_data, po_valid, abort_err, pad_err, frame_cnt, state_dbg
  );

  modport slave (
    input  si_data, si_valid, cfg_length, cfg_msb, cfg_fill, cfg_low,
    output po_data, po_valid, abort_err, pad_err, frame_cnt, state_dbg
  );
endinterface

// File: rtl/sti_rx_deserializer.sv
// STI link receiver: rebuilds a 16-bit word from an 8/16/24/32-bit serial frame.
// Define PAD_CHECK_EN to flag nonzero pad bits on 24/32-bit frames via pad_err.
module sti_rx_deserializer #(
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sti_rx_deserializer_if.slave   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       cnt_q;
  logic [30:0]      shift_q;
  logic [31:0]      shift_d;
  logic [1:0]       len_q;
  logic             msb_q, fill_q, low_q;
  logic             start, finish, abort;
  logic [15:0]      word_d;
  logic [15:0]      field;
  logic [7:0]       byte_v;
  logic             pad_bad;
  logic [15:0]      po_data_q;
  logic             po_valid_q, abort_err_q, pad_err_q;
  logic [CNT_W-1:0] frame_cnt_q;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // Completion is decided on the edge that samples the last bit, so RECV never
  // sees cnt_q == N; any gap in si_valid while in RECV is a truncated frame.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    shift_d = {shift_q, bus.si_data};
    case (state_q)
      IDLE: begin
        if (bus.si_valid) begin
          start   = 1'b1;
          state_d = RECV;
          shift_d = {31'd0, bus.si_data};
        end
      end
      RECV: begin
        if (!bus.si_valid) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == {1'b0, len_q, 3'b111}) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Word reconstruction from the frame as it will look after this edge's shift.
  always_comb begin
    word_d = 16'd0;
    field  = 16'd0;
    byte_v = 8'd0;
    case (len_q)
      2'd0: begin
        byte_v = msb_q ? shift_d[7:0] : rev8(shift_d[7:0]);
        word_d = low_q ? {byte_v, 8'h00} : {8'h00, byte_v};
      end
      2'd1: word_d = msb_q ? shift_d[15:0] : rev16(shift_d[15:0]);
      2'd2: begin
        field  = (fill_q == msb_q) ? shift_d[23:8] : shift_d[15:0];
        word_d = msb_q ? field : rev16(field);
      end
      default: begin
        field  = (fill_q == msb_q) ? shift_d[31:16] : shift_d[15:0];
        word_d = msb_q ? field : rev16(field);
      end
    endcase
  end

`ifdef PAD_CHECK_EN
  logic [15:0] pad;

  always_comb begin
    pad = 16'd0;
    case (len_q)
      2'd2:    pad = (fill_q == msb_q) ? {8'h00, shift_d[7:0]} : {8'h00, shift_d[23:16]};
      2'd3:    pad = (fill_q == msb_q) ? shift_d[15:0] : shift_d[31:16];
      default: pad = 16'd0;
    endcase
  end

  assign pad_bad = len_q[1] && (pad != 16'd0);
`else
  assign pad_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= 6'd0;
      shift_q     <= 31'd0;
      len_q       <= 2'd0;
      msb_q       <= 1'b0;
      fill_q      <= 1'b0;
      low_q       <= 1'b0;
      po_data_q   <= 16'd0;
      po_valid_q  <= 1'b0;
      abort_err_q <= 1'b0;
      pad_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      po_valid_q  <= finish;
      abort_err_q <= abort;
      pad_err_q   <= finish & pad_bad;
      if (start) begin
        len_q   <= bus.cfg_length;
        msb_q   <= bus.cfg_msb;
        fill_q  <= bus.cfg_fill;
        low_q   <= bus.cfg_low;
        cnt_q   <= 6'd1;
        shift_q <= shift_d[30:0];
      end else if (state_q == RECV && bus.si_valid) begin
        cnt_q   <= cnt_q + 6'd1;
        shift_q <= shift_d[30:0];
      end
      if (finish) begin
        po_data_q   <= word_d;
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign bus.po_data   = po_data_q;
  assign bus.po_valid  = po_valid_q;
  assign bus.abort_err = abort_err_q;
  assign bus.pad_err   = pad_err_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_sti_rx_deserializer.sv
// Bench for sti_rx_deserializer: directed vectors, corner sequences and a random
// frame stream checked against a transmitter-side model of the link.
module tb_sti_rx_deserializer;
  localparam int CNT_W = 8;
`ifdef PAD_CHECK_EN
  localparam logic PAD_EN = 1'b1;
`else
  localparam logic PAD_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sti_rx_deserializer_if #(.CNT_W(CNT_W)) bus ();
  sti_rx_deserializer #(.CNT_W(CNT_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  // ---------------- scoreboard state ----------------
  int              checks = 0;
  int              errors = 0;
  logic [24:0]     exp_q[$];          // {pad_err, frame_cnt, po_data}
  int              exp_abort = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [15:0]     last_word = 16'd0;
  logic [24:0]     mon_e;

  typedef struct {
    logic [1:0]  len;
    logic        msb;
    logic        fill;
    logic        low;
    logic [31:0] frame;
    logic [15:0] exp_data;
    logic        exp_pad;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transmitter view) ----------------
  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Builds the N-bit frame a transmitter would send for this payload and pad.
  function automatic logic [31:0] make_frame(input logic [1:0] len, input logic msb,
                                             input logic fill, input logic low,
                                             input logic [15:0] payload, input logic [15:0] pad);
    int          n;
    logic [7:0]  b;
    logic [15:0] fld;
    logic [15:0] padm;
    logic [31:0] f;
    n    = 8 * (int'(len) + 1);
    f    = 32'd0;
    padm = (n == 24) ? (pad & 16'h00FF) : pad;
    if (n == 8) begin
      b = low ? payload[15:8] : payload[7:0];
      f = {24'd0, msb ? b : rev8(b)};
    end else if (n == 16) begin
      f = {16'd0, msb ? payload : rev16(payload)};
    end else begin
      fld = msb ? payload : rev16(payload);
      if (fill == msb) f = (32'(fld) << (n - 16)) | 32'(padm);
      else             f = (32'(padm) << 16) | 32'(fld);
    end
    return f;
  endfunction

  function automatic logic [15:0] model_word(input logic [1:0] len, input logic low,
                                             input logic [15:0] payload);
    if (len != 2'd0) return payload;
    return low ? {payload[15:8], 8'h00} : {8'h00, payload[7:0]};
  endfunction

  function automatic logic model_pad_err(input logic [1:0] len, input logic [15:0] pad);
    logic [15:0] padm;
    padm = (len == 2'd2) ? (pad & 16'h00FF) : pad;
    return PAD_EN && (len >= 2'd2) && (padm != 16'd0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    bus.si_valid = 1'b0;
    bus.si_data  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends the first nbits bits of frame f (MSB of the N-bit frame first); the
  // config inputs are scrambled after bit 0 since only the frame start counts.
  task automatic send_frame(input logic [1:0] len, input logic msb, input logic fill,
                            input logic low, input logic [31:0] f, input int nbits);
    int n;
    n = 8 * (int'(len) + 1);
    bus.cfg_length = len;
    bus.cfg_msb    = msb;
    bus.cfg_fill   = fill;
    bus.cfg_low    = low;
    for (int i = 0; i < nbits; i++) begin
      bus.si_valid = 1'b1;
      bus.si_data  = f[n-1-i];
      @(posedge clk);
      #1;
      bus.cfg_length = 2'($urandom_range(0, 3));
      bus.cfg_msb    = 1'($urandom_range(0, 1));
      bus.cfg_fill   = 1'($urandom_range(0, 1));
      bus.cfg_low    = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic expect_good(input logic [15:0] w, input logic p);
    exp_cnt   = exp_cnt + 1'b1;
    exp_q.push_back({p, exp_cnt, w});
    last_word = w;
  endtask

  task automatic send_good(input logic [1:0] len, input logic msb, input logic fill,
                           input logic low, input logic [15:0] payload, input logic [15:0] pad);
    expect_good(model_word(len, low, payload), model_pad_err(len, pad));
    send_frame(len, msb, fill, low, make_frame(len, msb, fill, low, payload, pad),
               8 * (int'(len) + 1));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.po_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_po_valid actual=1 required=0 data=%h", bus.po_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("po_data", 32'(bus.po_data), 32'(mon_e[15:0]));
          check("frame_cnt", 32'(bus.frame_cnt), 32'(mon_e[23:16]));
          check("pad_err", 32'(bus.pad_err), 32'(mon_e[24]));
        end
      end else if (bus.pad_err) begin
        checks++;
        errors++;
        $display("FAIL pad_err_without_po_valid actual=1 required=0");
      end
      if (bus.abort_err) begin
        if (exp_abort > 0) exp_abort--;
        else begin
          checks++;
          errors++;
          $display("FAIL unexpected_abort_err actual=1 required=0");
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [1:0]  r_len;
    logic        r_msb, r_fill, r_low;
    logic [15:0] r_pay, r_pad;
    logic [CNT_W-1:0] cnt_before;
    int          n;

    vecs[0] = '{2'd1, 1'b1, 1'b0, 1'b0, 32'h0000_A5C3, 16'hA5C3, 1'b0};
    vecs[1] = '{2'd0, 1'b0, 1'b0, 1'b1, 32'h0000_00C0, 16'h0300, 1'b0};
    vecs[2] = '{2'd3, 1'b1, 1'b1, 1'b0, 32'h1234_0000, 16'h1234, 1'b0};
    vecs[3] = '{2'd2, 1'b0, 1'b0, 1'b0, 32'h0080_0100, 16'h8001, 1'b0};
    vecs[4] = '{2'd3, 1'b1, 1'b1, 1'b0, 32'hBEEF_0100, 16'hBEEF, PAD_EN};
    vecs[5] = '{2'd0, 1'b1, 1'b0, 1'b0, 32'h0000_005A, 16'h005A, 1'b0};
    vecs[6] = '{2'd1, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 16'h8000, 1'b0};
    vecs[7] = '{2'd3, 1'b0, 1'b1, 1'b0, 32'h0000_0003, 16'hC000, 1'b0};
    vecs[8] = '{2'd2, 1'b1, 1'b0, 1'b0, 32'h00FF_1357, 16'h1357, PAD_EN};

    reset_n        = 1'b0;
    bus.si_data    = 1'b0;
    bus.si_valid   = 1'b0;
    bus.cfg_length = 2'd0;
    bus.cfg_msb    = 1'b0;
    bus.cfg_fill   = 1'b0;
    bus.cfg_low    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_po_data", 32'(bus.po_data), 32'h0);
    check("reset_po_valid", 32'(bus.po_valid), 32'h0);
    check("reset_abort_err", 32'(bus.abort_err), 32'h0);
    check("reset_pad_err", 32'(bus.pad_err), 32'h0);
    check("reset_frame_cnt", 32'(bus.frame_cnt), 32'h0);
    check("reset_state", 32'(bus.state_dbg), 32'h0);
    reset_n = 1'b1;
    idle(2);

    // 16-bit MSB-first frame: strobe in the cycle right after the last bit only.
    expect_good(16'hA5C3, 1'b0);
    send_frame(2'd1, 1'b1, 1'b0, 1'b0, 32'h0000_A5C3, 16);
    check("t1_po_valid_latency", 32'(bus.po_valid), 32'h1);
    check("t1_back_to_idle", 32'(bus.state_dbg), 32'h0);
    idle(1);
    check("t1_po_valid_one_cycle", 32'(bus.po_valid), 32'h0);
    check("t1_po_data_holds", 32'(bus.po_data), 32'hA5C3);
    idle(1);

    for (int i = 0; i < 9; i++) begin
      expect_good(vecs[i].exp_data, vecs[i].exp_pad);
      send_frame(vecs[i].len, vecs[i].msb, vecs[i].fill, vecs[i].low, vecs[i].frame,
                 8 * (int'(vecs[i].len) + 1));
      idle(2);
    end

    // Truncated 16-bit frame after 9 bits.
    exp_abort++;
    send_frame(2'd1, 1'b1, 1'b0, 1'b0, 32'h0000_FFFF, 9);
    check("abort_mid_recv", 32'(bus.state_dbg), 32'h1);
    idle(1);
    check("abort_err_strobe", 32'(bus.abort_err), 32'h1);
    check("abort_po_data_holds", 32'(bus.po_data), 32'(last_word));
    check("abort_frame_cnt_holds", 32'(bus.frame_cnt), 32'(exp_cnt));
    check("abort_po_valid_low", 32'(bus.po_valid), 32'h0);
    idle(1);
    check("abort_err_one_cycle", 32'(bus.abort_err), 32'h0);
    send_good(2'd1, 1'b1, 1'b0, 1'b0, 16'hC0DE, 16'h0);
    idle(2);

    // Back-to-back 8-bit frames with si_valid held high.
    cnt_before = exp_cnt;
    send_good(2'd0, 1'b1, 1'b0, 1'b0, 16'h0011, 16'h0);
    check("b2b_strobe_1", 32'(bus.po_valid), 32'h1);
    send_good(2'd0, 1'b1, 1'b0, 1'b0, 16'h0022, 16'h0);
    check("b2b_strobe_2", 32'(bus.po_valid), 32'h1);
    send_good(2'd0, 1'b1, 1'b0, 1'b0, 16'h0033, 16'h0);
    check("b2b_strobe_3", 32'(bus.po_valid), 32'h1);
    idle(1);
    check("b2b_frame_cnt", 32'(bus.frame_cnt), 32'(cnt_before + 8'd3));
    idle(2);

    // Random frame stream: mixed lengths/configs, occasional truncation, random gaps.
    for (int k = 0; k < 80; k++) begin
      r_len  = 2'($urandom_range(0, 3));
      r_msb  = 1'($urandom_range(0, 1));
      r_fill = 1'($urandom_range(0, 1));
      r_low  = 1'($urandom_range(0, 1));
      r_pay  = 16'($urandom_range(0, 65535));
      r_pad  = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
      n      = 8 * (int'(r_len) + 1);
      if ($urandom_range(0, 7) == 0) begin
        exp_abort++;
        send_frame(r_len, r_msb, r_fill, r_low,
                   make_frame(r_len, r_msb, r_fill, r_low, r_pay, r_pad),
                   int'($urandom_range(1, n - 1)));
        idle(int'($urandom_range(1, 3)));
      end else begin
        send_good(r_len, r_msb, r_fill, r_low, r_pay, r_pad);
        if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
      end
    end
    idle(3);

    // Reset asserted mid-frame clears everything at once.
    send_frame(2'd3, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_po_data", 32'(bus.po_data), 32'h0);
    check("midreset_frame_cnt", 32'(bus.frame_cnt), 32'h0);
    check("midreset_state", 32'(bus.state_dbg), 32'h0);
    check("midreset_strobes", 32'({bus.po_valid, bus.abort_err, bus.pad_err}), 32'h0);
    exp_cnt = '0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
    send_good(2'd1, 1'b0, 1'b0, 1'b0, 16'h6A17, 16'h0);
    idle(2);

    // Counter wrap: 256 more back-to-back bytes bring frame_cnt past 255 to 0.
    for (int k = 0; k < 256; k++) begin
      send_good(2'd0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 65535)), 16'h0);
    end
    idle(3);
    check("wrap_frame_cnt", 32'(bus.frame_cnt), 32'h1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    check("aborts_seen", 32'(exp_abort), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
